// File: rtl/expr_eval.sv
// ---------------------------------------------------------------------------
// expr_eval
//   Byte-serial evaluator for ASCII expressions of unsigned decimal numbers
//   joined by '+' and '-'. It flags whether the string consumed so far is a
//   complete valid expression and evaluates it modulo 2^W.
//
//   Optional feature: define EXPR_MUL_EN to accept '*' as an operator that
//   binds tighter than '+'/'-'. Without it '*' is an illegal character and no
//   term multiplier is built.
//
// Ports
//   clk       rising-edge clock
//   clr       synchronous active-high reset; only way out of the error state
//   in_valid  qualifies in; a character is consumed on an edge only when high
//   in        ASCII character
//   out       high when the consumed string is a complete valid expression
//   err       sticky syntax error
//   result    value of the expression so far (0 while in error)
//   ovf       sticky wrap indicator (also shows wrap of the pending term)
//
// Handshake: there is no back-pressure. A character is taken on every rising
// edge where in_valid=1; with in_valid=0 all state holds. clr beats in_valid.
// Outputs reflect a character one edge after it is taken.
// ---------------------------------------------------------------------------
module expr_eval #(
   parameter int W          = 8,
   parameter int MAX_DIGITS = 3
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [7:0]   in,
   output logic         out,
   output logic         err,
   output logic [W-1:0] result,
   output logic         ovf
);

   localparam int DW = $clog2(MAX_DIGITS + 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      NUM   = 2'd1,
      OP    = 2'd2,
      ERR   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      C_DIGIT = 2'd0,
      C_ADDSUB = 2'd1,
      C_MUL   = 2'd2,
      C_BAD   = 2'd3
   } cls_t;

   state_t         state, state_next;
   cls_t           cls;
   logic [W-1:0]   sum, cur;
   logic           neg, ovf_r;
   logic [DW-1:0]  dcnt;
   logic [3:0]     dval;

   logic           do_first, do_digit, do_commit, do_mul;

   // Character classification
   always_comb begin
      cls = C_BAD;
      if (in >= 8'h30 && in <= 8'h39)
         cls = C_DIGIT;
      else if (in == 8'h2B || in == 8'h2D)
         cls = C_ADDSUB;
`ifdef EXPR_MUL_EN
      else if (in == 8'h2A)
         cls = C_MUL;
`endif
   end

   assign dval = in[3:0];

   // Digit accumulation with headroom to detect wrap of cur*10+digit.
   logic [W+3:0] acc;
   logic         acc_wrap;
   assign acc      = (W+4)'(cur) * (W+4)'(10) + (W+4)'(dval);
   assign acc_wrap = |acc[W+3:W];

   // Pending term value: term*cur when multiplication exists, else cur.
   logic [W-1:0] prod;
   logic         prod_wrap;
`ifdef EXPR_MUL_EN
   logic [W-1:0]   term;
   logic [2*W-1:0] prod_full;
   assign prod_full = (2*W)'(term) * (2*W)'(cur);
   assign prod      = prod_full[W-1:0];
   assign prod_wrap = |prod_full[2*W-1:W];
`else
   assign prod      = cur;
   assign prod_wrap = 1'b0;
`endif

   // Live combination sum +/- prod; carry or borrow both count as wrap.
   logic [W:0]   add_full, sub_full;
   logic [W-1:0] live;
   logic         live_wrap;
   assign add_full  = {1'b0, sum} + {1'b0, prod};
   assign sub_full  = {1'b0, sum} - {1'b0, prod};
   assign live      = neg ? sub_full[W-1:0] : add_full[W-1:0];
   assign live_wrap = prod_wrap | (neg ? sub_full[W] : add_full[W]);

   // Next-state and datapath strobes
   always_comb begin
      state_next = state;
      do_first   = 1'b0;
      do_digit   = 1'b0;
      do_commit  = 1'b0;
      do_mul     = 1'b0;
      if (in_valid) begin
         case (state)
            EMPTY, OP: begin
               if (cls == C_DIGIT) begin
                  state_next = NUM;
                  do_first   = 1'b1;
               end else begin
                  state_next = ERR;
               end
            end
            NUM: begin
               case (cls)
                  C_DIGIT: begin
                     if (dcnt < DW'(MAX_DIGITS))
                        do_digit = 1'b1;
                     else
                        state_next = ERR;
                  end
                  C_ADDSUB: begin
                     state_next = OP;
                     do_commit  = 1'b1;
                  end
                  C_MUL: begin
                     state_next = OP;
                     do_mul     = 1'b1;
                  end
                  default: state_next = ERR;
               endcase
            end
            default: state_next = ERR;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (clr)
         state <= EMPTY;
      else
         state <= state_next;
   end

   // Datapath registers; strobes are mutually exclusive.
   always_ff @(posedge clk) begin
      if (clr) begin
         sum   <= '0;
         cur   <= '0;
         neg   <= 1'b0;
         dcnt  <= '0;
         ovf_r <= 1'b0;
`ifdef EXPR_MUL_EN
         term  <= W'(1);
`endif
      end else begin
         if (do_first) begin
            cur  <= W'(dval);
            dcnt <= DW'(1);
         end
         if (do_digit) begin
            cur   <= acc[W-1:0];
            dcnt  <= dcnt + DW'(1);
            ovf_r <= ovf_r | acc_wrap;
         end
         if (do_commit) begin
            sum   <= live;
            neg   <= (in == 8'h2D);
            ovf_r <= ovf_r | live_wrap;
`ifdef EXPR_MUL_EN
            term  <= W'(1);
`endif
         end
`ifdef EXPR_MUL_EN
         if (do_mul) begin
            term  <= prod;
            ovf_r <= ovf_r | prod_wrap;
         end
`endif
      end
   end

   // Outputs decoded from registered state
   always_comb begin
      out    = (state == NUM);
      err    = (state == ERR);
      ovf    = ovf_r | ((state == NUM) & live_wrap);
      result = '0;
      case (state)
         NUM:       result = live;
         EMPTY, OP: result = sum;
         default:   result = '0;
      endcase
   end

endmodule

// File: tb/tb_expr_eval.sv
// ---------------------------------------------------------------------------
// tb_expr_eval
//   Directed-vector bench for expr_eval (W=8, MAX_DIGITS=3). Each scenario
//   task drives characters and compares {out,err,ovf,result} against
//   hand-computed values one edge after each character.
// ---------------------------------------------------------------------------
module tb_expr_eval;

   logic       clk;
   logic       clr;
   logic       in_valid;
   logic [7:0] in;
   logic       out;
   logic       err;
   logic [7:0] result;
   logic       ovf;

   int checks;
   int fails;

   expr_eval #(.W(8), .MAX_DIGITS(3)) dut (
      .clk      (clk),
      .clr      (clr),
      .in_valid (in_valid),
      .in       (in),
      .out      (out),
      .err      (err),
      .result   (result),
      .ovf      (ovf)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drivers: inputs change #1 after an edge; outputs sampled #1 after the
   // next edge.
   task automatic send(input logic [7:0] c);
      in_valid = 1'b1;
      in       = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in       = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++)
         send(s[i]);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] exp_v;
      do_clr();
      exp_v = {1'b0, 1'b0, 1'b0, 8'd0};
      checks++;
      if ({out, err, ovf, result} !== exp_v) begin
         fails++;
         $display("FAIL reset: got out/err/ovf/result=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                  out, err, ovf, result, exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
   endtask

   // "1","+","3","+", clr, "1"
   task automatic test_basic();
      string      s;
      logic [7:0] exp_r [4];
      logic       exp_o [4];
      s = "1+3+";
      exp_r = '{8'd1, 8'd1, 8'd4, 8'd4};
      exp_o = '{1'b1, 1'b0, 1'b1, 1'b0};
      do_clr();
      for (int i = 0; i < 4; i++) begin
         send(s[i]);
         checks++;
         if ({out, err, ovf, result} !== {exp_o[i], 1'b0, 1'b0, exp_r[i]}) begin
            fails++;
            $display("FAIL basic[%0d]: got out/err/ovf/result=%b/%b/%b/%0d expected %b/0/0/%0d",
                     i, out, err, ovf, result, exp_o[i], exp_r[i]);
         end
      end
      do_clr();
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL basic_clr: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/0/0",
                  out, err, ovf, result);
      end
      send("1");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
         fails++;
         $display("FAIL basic_after_clr: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/1",
                  out, err, ovf, result);
      end
   endtask

   // "12-5"
   task automatic test_sub();
      do_clr();
      send_str("12");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd12}) begin
         fails++;
         $display("FAIL sub_12: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/12",
                  out, err, ovf, result);
      end
      send("-");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b0, 8'd12}) begin
         fails++;
         $display("FAIL sub_op: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/0/12",
                  out, err, ovf, result);
      end
      send("5");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd7}) begin
         fails++;
         $display("FAIL sub_final: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/7",
                  out, err, ovf, result);
      end
   endtask

   // "3-5" then "+9"; ovf sticky until clr
   task automatic test_wrap();
      do_clr();
      send_str("3-5");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b1, 8'd254}) begin
         fails++;
         $display("FAIL wrap_borrow: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/1/254",
                  out, err, ovf, result);
      end
      send("+");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b1, 8'd254}) begin
         fails++;
         $display("FAIL wrap_commit: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/1/254",
                  out, err, ovf, result);
      end
      send("9");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b1, 8'd7}) begin
         fails++;
         $display("FAIL wrap_sticky: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/1/7",
                  out, err, ovf, result);
      end
      do_clr();
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL wrap_clr: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/0/0",
                  out, err, ovf, result);
      end
   endtask

   // "1++2", leading operator, and too many digits
   task automatic test_err();
      do_clr();
      send_str("1++");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL err_double_op: got out/err/ovf/result=%b/%b/%b/%0d expected 0/1/0/0",
                  out, err, ovf, result);
      end
      send("2");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL err_sticky: got out/err/ovf/result=%b/%b/%b/%0d expected 0/1/0/0",
                  out, err, ovf, result);
      end
      do_clr();
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL err_clr: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/0/0",
                  out, err, ovf, result);
      end
      send("-");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL err_leading_op: got out/err/ovf/result=%b/%b/%b/%0d expected 0/1/0/0",
                  out, err, ovf, result);
      end
      do_clr();
      send_str("123");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd123}) begin
         fails++;
         $display("FAIL err_3digits: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/123",
                  out, err, ovf, result);
      end
      send("4");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL err_4digits: got out/err/ovf/result=%b/%b/%b/%0d expected 0/1/0/0",
                  out, err, ovf, result);
      end
      do_clr();
      send_str("7x");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL err_bad_char: got out/err/ovf/result=%b/%b/%b/%0d expected 0/1/0/0",
                  out, err, ovf, result);
      end
   endtask

   task automatic test_mul();
`ifdef EXPR_MUL_EN
      do_clr();
      send_str("2+3*");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
         fails++;
         $display("FAIL mul_op: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/0/2",
                  out, err, ovf, result);
      end
      send("4");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd14}) begin
         fails++;
         $display("FAIL mul_precedence: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/14",
                  out, err, ovf, result);
      end
      do_clr();
      send_str("2*3-1");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd5}) begin
         fails++;
         $display("FAIL mul_then_sub: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/5",
                  out, err, ovf, result);
      end
`else
      do_clr();
      send_str("2*");
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL mul_disabled: got out/err/ovf/result=%b/%b/%b/%0d expected 0/1/0/0",
                  out, err, ovf, result);
      end
`endif
   endtask

   // in_valid low with junk on in between '4' and '2'
   task automatic test_valid_gap();
      logic [7:0] junk [3];
      junk = '{8'h2B, 8'h78, 8'h2D};
      do_clr();
      send("4");
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b0;
         in       = junk[i];
         @(posedge clk);
         #1;
      end
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd4}) begin
         fails++;
         $display("FAIL gap_hold: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/4",
                  out, err, ovf, result);
      end
      send("2");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd42}) begin
         fails++;
         $display("FAIL gap_final: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/42",
                  out, err, ovf, result);
      end
   endtask

   // "255+1" wraps to 0
   task automatic test_boundary();
      do_clr();
      send_str("255");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd255}) begin
         fails++;
         $display("FAIL bound_255: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/255",
                  out, err, ovf, result);
      end
      send_str("+1");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b1, 8'd0}) begin
         fails++;
         $display("FAIL bound_wrap: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/1/0",
                  out, err, ovf, result);
      end
      do_clr();
      send_str("999");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b1, 8'd231}) begin
         fails++;
         $display("FAIL bound_999: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/1/231",
                  out, err, ovf, result);
      end
   endtask

   // clr mid-number with a simultaneous valid character
   task automatic test_clr_priority();
      do_clr();
      send_str("5+6");
      clr      = 1'b1;
      in_valid = 1'b1;
      in       = "7";
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({out, err, ovf, result} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL clr_priority: got out/err/ovf/result=%b/%b/%b/%0d expected 0/0/0/0",
                  out, err, ovf, result);
      end
      send("8");
      checks++;
      if ({out, err, ovf, result} !== {1'b1, 1'b0, 1'b0, 8'd8}) begin
         fails++;
         $display("FAIL clr_fresh_num: got out/err/ovf/result=%b/%b/%b/%0d expected 1/0/0/8",
                  out, err, ovf, result);
      end
   endtask

   initial begin
      checks   = 0;
      fails    = 0;
      clr      = 1'b1;
      in_valid = 1'b0;
      in       = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;

      test_reset();
      test_basic();
      test_sub();
      test_wrap();
      test_err();
      test_mul();
      test_valid_gap();
      test_boundary();
      test_clr_priority();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
